// File: rtl/psw_pkg.sv
// Shared constants, counter widths and channel state type for the push-button conditioner.
package psw_pkg;

    localparam int NUM_PSW = 4;

    localparam int DEB_CYCLES_DEF  = 20;
    localparam int LONG_CYCLES_DEF = 500;
    localparam int RPT_CYCLES_DEF  = 100;

    // Widths cover the largest legal parameter value, not the defaults.
    localparam int DEB_MAX  = 255;
    localparam int LONG_MAX = 4095;
    localparam int RPT_MAX  = 4095;

    localparam int DEB_W  = $clog2(DEB_MAX + 1);
    localparam int LONG_W = $clog2(LONG_MAX + 1);
    localparam int RPT_W  = $clog2(RPT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        REPEAT
    } psw_state_e;

endpackage

// File: rtl/psw_channel.sv
// One push-button channel: two-flop synchronizer, debouncer, press/release pulses,
// and the long-hold / auto-repeat state machine.
module psw_channel
    import psw_pkg::*;
#(
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int LONG_CYCLES = LONG_CYCLES_DEF,
    parameter int RPT_CYCLES  = RPT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic lvl,
    output logic prs,
    output logic rel,
    output logic long_hold,
    output logic rpt
);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
    localparam logic [RPT_W-1:0]  RPT_LAST  = RPT_W'(RPT_CYCLES - 1);

    logic              s1;
    logic              s2;
    logic [DEB_W-1:0]  deb_cnt;
    logic [LONG_W-1:0] hold_cnt;
    logic [RPT_W-1:0]  rpt_cnt;
    psw_state_e        state;

    logic accept;
    logic rise;
    logic fall;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        accept = (s2 != lvl) && (deb_cnt == DEB_LAST);
        rise   = accept && s2;
        fall   = accept && !s2;
    end

    // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            deb_cnt   <= '0;
            hold_cnt  <= '0;
            rpt_cnt   <= '0;
            lvl       <= 1'b0;
            prs       <= 1'b0;
            rel       <= 1'b0;
            long_hold <= 1'b0;
            rpt       <= 1'b0;
            state     <= IDLE;
        end else begin
            s1  <= raw;
            s2  <= s1;
            prs <= rise;
            rel <= fall;
            rpt <= 1'b0;

            if ((s2 == lvl) || accept) begin
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end

            if (accept) begin
                lvl <= s2;
            end

            // A debounced fall is checked first in every state, so release beats a repeat tick.
            case (state)
                IDLE: begin
                    if (rise) begin
                        state    <= HELD;
                        hold_cnt <= '0;
                    end
                end
                HELD: begin
                    if (fall) begin
                        state <= IDLE;
                    end else if (hold_cnt == LONG_LAST) begin
                        state     <= REPEAT;
                        long_hold <= 1'b1;
                        rpt       <= 1'b1;
                        rpt_cnt   <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (fall) begin
                        state     <= IDLE;
                        long_hold <= 1'b0;
                    end else if (rpt_cnt == RPT_LAST) begin
                        rpt     <= 1'b1;
                        rpt_cnt <= '0;
                    end else begin
                        rpt_cnt <= rpt_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/psw_conditioner.sv
// Four independent push-button conditioning channels sharing one clock and reset.
module psw_conditioner
    import psw_pkg::*;
#(
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int LONG_CYCLES = LONG_CYCLES_DEF,
    parameter int RPT_CYCLES  = RPT_CYCLES_DEF
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic [NUM_PSW-1:0] PSW_IN,
    output logic [NUM_PSW-1:0] PSW_LVL,
    output logic [NUM_PSW-1:0] PSW_PRS,
    output logic [NUM_PSW-1:0] PSW_REL,
    output logic [NUM_PSW-1:0] PSW_LONG,
    output logic [NUM_PSW-1:0] PSW_RPT
);

    for (genvar i = 0; i < NUM_PSW; i++) begin : g_ch
        psw_channel #(
            .DEB_CYCLES (DEB_CYCLES),
            .LONG_CYCLES(LONG_CYCLES),
            .RPT_CYCLES (RPT_CYCLES)
        ) u_ch (
            .clk      (CLOCK),
            .rst_n    (RESET),
            .raw      (PSW_IN[i]),
            .lvl      (PSW_LVL[i]),
            .prs      (PSW_PRS[i]),
            .rel      (PSW_REL[i]),
            .long_hold(PSW_LONG[i]),
            .rpt      (PSW_RPT[i])
        );
    end

endmodule

// File: tb/tb_psw_conditioner.sv
// Self-checking bench: directed scenarios with literal edge counts plus randomized
// stimulus compared every cycle against a run-length / elapsed-time reference model.
module tb_psw_conditioner;

    localparam int DEB  = 20;
    localparam int LONG = 500;
    localparam int RPT  = 100;

    logic       CLOCK;
    logic       RESET;
    logic [3:0] PSW_IN;
    logic [3:0] PSW_LVL;
    logic [3:0] PSW_PRS;
    logic [3:0] PSW_REL;
    logic [3:0] PSW_LONG;
    logic [3:0] PSW_RPT;

    int n_checks = 0;
    int n_errors = 0;

    psw_conditioner #(
        .DEB_CYCLES (DEB),
        .LONG_CYCLES(LONG),
        .RPT_CYCLES (RPT)
    ) dut (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .PSW_IN  (PSW_IN),
        .PSW_LVL (PSW_LVL),
        .PSW_PRS (PSW_PRS),
        .PSW_REL (PSW_REL),
        .PSW_LONG(PSW_LONG),
        .PSW_RPT (PSW_RPT)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a level flips after DEB consecutive synchronized cycles that
    // disagree with it; long/repeat follow from the number of cycles since the press.
    logic [3:0] m_s1, m_s2, m_lvl, m_prs, m_rel, m_long, m_rpt;
    int         m_run [4];
    int         m_age [4];

    task automatic model_step(input logic [3:0] in, input logic rst);
        if (!rst) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_prs = '0;
            m_rel = '0; m_long = '0; m_rpt = '0;
            for (int i = 0; i < 4; i++) begin
                m_run[i] = 0;
                m_age[i] = -1;
            end
        end else begin
            m_prs = '0; m_rel = '0; m_rpt = '0;
            for (int i = 0; i < 4; i++) begin
                if (m_s2[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_lvl[i] = m_s2[i];
                        m_run[i] = 0;
                        if (m_lvl[i]) begin
                            m_prs[i] = 1'b1;
                            m_age[i] = 0;
                        end else begin
                            m_rel[i]  = 1'b1;
                            m_long[i] = 1'b0;
                            m_age[i]  = -1;
                        end
                    end
                end else begin
                    m_run[i] = 0;
                end
                if (m_age[i] >= 0 && !m_prs[i]) begin
                    m_age[i]++;
                    if (m_age[i] >= LONG && ((m_age[i] - LONG) % RPT) == 0) begin
                        m_long[i] = 1'b1;
                        m_rpt[i]  = 1'b1;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = in;
        end
    endtask

    logic [3:0] in_q;
    logic       rst_q;
    logic       edge_seen = 1'b0;
    int         prs_cnt [4] = '{0, 0, 0, 0};
    int         rel_cnt [4] = '{0, 0, 0, 0};

    always @(posedge CLOCK) begin
        in_q      <= PSW_IN;
        rst_q     <= RESET;
        edge_seen <= 1'b1;
    end

    always @(negedge CLOCK) begin
        if (edge_seen) begin
            model_step(in_q, rst_q);
            check("model_lvl",  32'(PSW_LVL),  32'(m_lvl));
            check("model_prs",  32'(PSW_PRS),  32'(m_prs));
            check("model_rel",  32'(PSW_REL),  32'(m_rel));
            check("model_long", 32'(PSW_LONG), 32'(m_long));
            check("model_rpt",  32'(PSW_RPT),  32'(m_rpt));
            for (int i = 0; i < 4; i++) begin
                prs_cnt[i] += int'(PSW_PRS[i]);
                rel_cnt[i] += int'(PSW_REL[i]);
            end
        end
    end

    // After step(k) from a drive point, the outputs of the k-th following edge are visible.
    task automatic step(input int n);
        repeat (n) @(negedge CLOCK);
        #1;
    endtask

    int base_prs;
    int base_rel;
    int len;

    initial begin
        RESET  = 1'b0;
        PSW_IN = 4'b0000;

        // Reset holds everything at zero even with all buttons pressed.
        PSW_IN = 4'b1111;
        step(3);
        check("rst_lvl",  32'(PSW_LVL),  32'h0);
        check("rst_prs",  32'(PSW_PRS),  32'h0);
        check("rst_rel",  32'(PSW_REL),  32'h0);
        check("rst_long", 32'(PSW_LONG), 32'h0);
        check("rst_rpt",  32'(PSW_RPT),  32'h0);
        RESET = 1'b1;
        step(21);
        check("rst_prs_e21", 32'(PSW_PRS), 32'h0);
        step(1);
        check("rst_prs_e22", 32'(PSW_PRS), 32'hF);
        check("rst_lvl_e22", 32'(PSW_LVL), 32'hF);
        PSW_IN = 4'b0000;
        step(22);
        check("rst_rel_e22", 32'(PSW_REL), 32'hF);
        step(8);

        // Clean press and release on channel 0.
        PSW_IN = 4'b0001;
        step(21);
        check("clean_prs_e21", 32'(PSW_PRS), 32'h0);
        step(1);
        check("clean_prs_e22", 32'(PSW_PRS), 32'h1);
        check("clean_lvl_e22", 32'(PSW_LVL), 32'h1);
        step(1);
        check("clean_prs_e23", 32'(PSW_PRS), 32'h0);
        step(17);
        PSW_IN = 4'b0000;
        step(21);
        check("clean_rel_e21", 32'(PSW_REL), 32'h0);
        step(1);
        check("clean_rel_e22", 32'(PSW_REL), 32'h1);
        check("clean_lvl_rel", 32'(PSW_LVL), 32'h0);
        step(8);

        // Bounce on channel 1: toggling every 5 cycles must not get through.
        base_prs = prs_cnt[1];
        base_rel = rel_cnt[1];
        for (int k = 0; k < 20; k++) begin
            PSW_IN[1] = ~PSW_IN[1];
            step(5);
        end
        check("bounce_no_prs", 32'(prs_cnt[1] - base_prs), 32'h0);
        check("bounce_no_rel", 32'(rel_cnt[1] - base_rel), 32'h0);
        PSW_IN[1] = 1'b1;
        step(40);
        check("bounce_one_prs", 32'(prs_cnt[1] - base_prs), 32'h1);
        PSW_IN = 4'b0000;
        step(30);

        // Long hold on channel 2, released so the release lands on a repeat tick.
        PSW_IN = 4'b0100;
        step(22);
        check("long_prs_e22", 32'(PSW_PRS), 32'h4);
        step(499);
        check("long_long_e521", 32'(PSW_LONG), 32'h0);
        check("long_rpt_e521",  32'(PSW_RPT),  32'h0);
        step(1);
        check("long_long_e522", 32'(PSW_LONG), 32'h4);
        check("long_rpt_e522",  32'(PSW_RPT),  32'h4);
        step(1);
        check("long_rpt_e523", 32'(PSW_RPT), 32'h0);
        step(98);
        check("long_rpt_e621", 32'(PSW_RPT), 32'h0);
        step(1);
        check("long_rpt_e622", 32'(PSW_RPT), 32'h4);
        step(100);
        check("long_rpt_e722", 32'(PSW_RPT), 32'h4);
        step(78);
        PSW_IN = 4'b0000;
        step(21);
        check("long_long_e821", 32'(PSW_LONG), 32'h4);
        check("long_rel_e821",  32'(PSW_REL),  32'h0);
        step(1);
        check("long_rel_e822",  32'(PSW_REL),  32'h4);
        check("long_long_e822", 32'(PSW_LONG), 32'h0);
        check("long_rpt_e822",  32'(PSW_RPT),  32'h0);
        step(8);

        // Two channels pressed on the same edge.
        PSW_IN = 4'b1001;
        step(21);
        check("simul_prs_e21", 32'(PSW_PRS), 32'h0);
        step(1);
        check("simul_prs_e22", 32'(PSW_PRS), 32'h9);
        PSW_IN = 4'b0000;
        step(30);

        // Reset in the middle of a channel 3 hold: no release, then a fresh press.
        PSW_IN = 4'b1000;
        step(300);
        base_rel = rel_cnt[3];
        RESET = 1'b0;
        step(1);
        check("midrst_lvl",  32'(PSW_LVL),  32'h0);
        check("midrst_rel",  32'(PSW_REL),  32'h0);
        check("midrst_long", 32'(PSW_LONG), 32'h0);
        step(1);
        RESET = 1'b1;
        step(21);
        check("midrst_prs_e21", 32'(PSW_PRS), 32'h0);
        step(1);
        check("midrst_prs_e22", 32'(PSW_PRS), 32'h8);
        check("midrst_no_rel",  32'(rel_cnt[3] - base_rel), 32'h0);
        PSW_IN = 4'b0000;
        step(30);

        // Randomized segments: short glitches, long holds and occasional resets.
        for (int seg = 0; seg < 70; seg++) begin
            PSW_IN = 4'($urandom);
            if ($urandom_range(0, 3) == 0) len = $urandom_range(400, 900);
            else                           len = $urandom_range(1, 40);
            if ($urandom_range(0, 19) == 0) begin
                RESET = 1'b0;
                step($urandom_range(1, 3));
                RESET = 1'b1;
            end
            step(len);
        end
        PSW_IN = 4'b0000;
        step(40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/psw_conditioner.md
PSW_CONDITIONER -- requirements
Module: psw_conditioner

Interface
REQ-001 The block SHALL take parameter DEB_CYCLES, default 20, meaning consecutive stable cycles needed to accept a level change (legal range 2..255).
REQ-002 The block SHALL take parameter LONG_CYCLES, default 500, meaning held cycles after press before long-hold is declared (legal range 2..4095).
REQ-003 The block SHALL take parameter RPT_CYCLES, default 100, meaning the repeat-pulse period while long-held (legal range 1..4095).
REQ-004 Port CLOCK  input  1  SHALL be the single clock (1 kHz nominal, 1 ms period).
REQ-005 Port RESET  input  1  SHALL be the reset: synchronous, active-low.
REQ-006 Port PSW_IN  input  4  SHALL carry the raw asynchronous push-buttons (1 = pressed).
REQ-007 Port PSW_LVL  output  4  SHALL give the debounced button level.
REQ-008 Port PSW_PRS  output  4  SHALL give a one-cycle press pulse per channel.
REQ-009 Port PSW_REL  output  4  SHALL give a one-cycle release pulse per channel.
REQ-010 Port PSW_LONG  output  4  SHALL give the long-hold level per channel.
REQ-011 Port PSW_RPT  output  4  SHALL give a one-cycle auto-repeat pulse per channel.

Function
REQ-012 Each PSW_IN bit SHALL pass through a two-flop synchronizer (s1, s2) before any other logic.
REQ-013 Each channel SHALL run independently; there is no cross-channel priority or interaction.
REQ-014 Debounce counter: increments while s2 != PSW_LVL; clears to 0 whenever s2 == PSW_LVL.
REQ-015 When the counter equals DEB_CYCLES-1 and s2 != PSW_LVL, PSW_LVL SHALL take s2 on that edge and the counter SHALL clear.
REQ-016 Latency: a clean raw change SHALL reach PSW_LVL on the (DEB_CYCLES+2)th rising edge, counting the first edge that samples the new value as edge 1.
REQ-017 A bounce shorter than DEB_CYCLES synchronized cycles SHALL produce no output change.
REQ-018 PSW_PRS / PSW_REL SHALL be registered and asserted for exactly one cycle, in the same cycle PSW_LVL rises / falls.
REQ-019 Per-channel FSM states SHALL be IDLE, HELD, REPEAT.
REQ-020 IDLE->HELD on debounced rise; HELD->REPEAT when the hold counter reaches LONG_CYCLES-1; HELD or REPEAT->IDLE on debounced fall.
REQ-021 The hold counter SHALL clear on entry to HELD and increment by 1 per cycle in HELD.
REQ-022 On the HELD->REPEAT edge, PSW_LONG SHALL go to 1 and PSW_RPT SHALL pulse.
REQ-023 In REPEAT, PSW_RPT SHALL pulse every RPT_CYCLES cycles thereafter; the repeat counter wraps to 0 after each pulse.
REQ-024 PSW_LONG SHALL fall in the same cycle as PSW_REL.
REQ-025 If a release and a repeat tick coincide, the release SHALL win and PSW_RPT SHALL stay 0.
REQ-026 Counter widths SHALL be sized from the parameter maxima; counters never overflow or wrap except as stated in REQ-023.

Reset
REQ-027 While RESET=0 at a clock edge, all outputs, synchronizer flops and counters SHALL be 0 and all FSMs SHALL be in IDLE.
REQ-028 Reset asserted mid-press SHALL abort the channel with no PSW_REL pulse.
REQ-029 A button still held when RESET deasserts SHALL be re-debounced and SHALL produce a fresh PSW_PRS.

Structure
REQ-030 Shared package psw_pkg SHALL hold NUM_PSW=4, the default DEB/LONG/RPT constants, counter widths and the FSM state enum.
REQ-031 Per-channel logic SHALL live in sub-module psw_channel, instantiated 4 times by psw_conditioner.

Verification (defaults)
REQ-032 Reset test: PSW_IN=4'b1111 with RESET=0 for 3 edges -> all outputs 0; then PSW_PRS=4'b1111 on edge 22 after RESET=1.
REQ-033 Clean press: PSW_IN[0] 0->1 held 40 cycles -> PSW_PRS[0] single pulse on edge 22 and PSW_LVL[0]=1; on release, PSW_REL[0] pulses 22 edges later.
REQ-034 Bounce: PSW_IN[1] toggling every 5 cycles for 100 cycles, then held at 1 -> no pulse during bouncing, then exactly one PSW_PRS[1].
REQ-035 Long hold: PSW_IN[2] held 800 cycles -> PSW_PRS at edge 22; PSW_LONG rises and PSW_RPT pulses at edge 522, then at 622 and 722; on release, PSW_LONG falls with PSW_REL.
REQ-036 Simultaneous: PSW_IN 0000->1001 on one edge -> PSW_PRS=4'b1001 in a single cycle.
REQ-037 Reset mid-hold: RESET=0 at cycle 300 of a PSW_IN[3] hold -> outputs 0 with no PSW_REL; PSW_PRS[3] pulses again on edge 22 after RESET=1.
